emaxi_wr: RTL and testbench
===========================

# emaxi_wr

AXI3 master write initiator: converts 104-bit emesh write packets into single AW/W/B transactions on a 32-bit AXI master port. It is the initiating counterpart of the `esaxi` slave write path and sits between the mesh write queue and the AXI interconnect. It holds one packet at a time, issues AW and W independently, and tracks up to `MAX_OUT` outstanding write responses.

## Interface
- `IDW`, 12, AXI ID width
- `AXI_ID`, 0, constant driven on `m_axi_awid`
- `MAX_OUT`, 4, max outstanding B responses (1..15)

- `m_axi_aclk`  in  1  clock
- `m_axi_aresetn`  in  1  reset; one clock, reset asynchronous active-low
- `wr_access`  in  1  packet valid
- `wr_packet`  in  104  [0] write, [2:1] datamode, [7:3] ctrlmode, [39:8] dstaddr, [71:40] data, [103:72] srcaddr (upper data word for doubles)
- `wr_wait`  out  1  backpressure; packet accepted on `wr_access && !wr_wait`
- `m_axi_awid`  out  IDW  = AXI_ID
- `m_axi_awaddr`  out  32; `m_axi_awlen` out 8; `m_axi_awsize` out 3; `m_axi_awburst` out 2
- `m_axi_awvalid`  out  1; `m_axi_awready`  in  1
- `m_axi_wdata`  out  32; `m_axi_wstrb`  out  4; `m_axi_wlast`  out  1
- `m_axi_wvalid`  out  1; `m_axi_wready`  in  1
- `m_axi_bid`  in  IDW (ignored); `m_axi_bresp`  in  2
- `m_axi_bvalid`  in  1; `m_axi_bready`  out  1
- `wr_error`  out  1  sticky write-response error (see Configuration)

## Operation
- Reset: all outputs 0; `awburst` 2'b01 once loaded; outstanding count 0.
- Accept loads AW and W registers, sets `awvalid`=1 and `wvalid`=1 and the beat index to 0.
- Datamode mapping:
  - 00 byte: `awsize`=0, `awlen`=0, `wstrb`=1<<addr[1:0], `wdata`=data[7:0] replicated x4.
  - 01 half: `awsize`=1, `awlen`=0, `wstrb`=addr[1]?4'b1100:4'b0011, `wdata`=data[15:0] x2, addr[0] forced 0.
  - 10 word: `awsize`=2, `awlen`=0, `wstrb`=4'hF, addr[1:0] forced 0.
  - 11 double: `awsize`=2, `awlen`=1, addr[2:0] forced 0; beat0 `wdata`=data, beat1 `wdata`=srcaddr.
- `awburst`=2'b01 (INCR) always; `wlast`=1 on the final beat (beat0 for single, beat1 for double).
- AW: `awvalid` drops the cycle after `awvalid && awready`; W beats advance on `wvalid && wready`; `wvalid` drops after the last beat handshakes.
- Busy = `awvalid || wvalid`.
- Outstanding counter: +1 on AW handshake, -1 on B handshake; both in the same cycle leaves it unchanged.
- `m_axi_bready` = (outstanding != 0).
- `wr_wait` = busy || (outstanding == MAX_OUT), decoded from registers only.
- Packets with `wr_packet[0]`=0 are accepted and dropped: no AXI activity.
- AW/W/B ordering: W may complete before or after AW; a B before its AW handshake is a protocol violation and has no defined response.
- Reset mid-transaction: asynchronous clear of valids, beat index and counter; any in-flight transaction is abandoned.

## Timing
- Accept at edge N → `awvalid`/`wvalid` high from N+1.
- Single beat with `awready`=`wready`=1: handshakes at N+1, valids low at N+2, `wr_wait` low N+2 → next accept at edge N+2. Peak throughput is 1 packet per 2 cycles.
- Double with ready held high: beats at N+1 and N+2, next accept at N+3.
- AXI outputs are stable while valid is high and ready is low.

## Configuration
- `EMAXI_WR_BRESP_ERR_EN` defined: `wr_error` is set on `bvalid && bready && bresp[1]` (SLVERR/DECERR). It is cleared only by reset.
- Undefined: `wr_error` is tied 0 and `bresp` is ignored.

## Test plan
- Word write, dstaddr 0x8000_0013, data 0xDEADBEEF, readies high → awaddr 0x8000_0010, awsize 2, awlen 0, wstrb F, wlast 1, `wr_wait` low 2 cycles after accept.
- Byte write to 0x...02, data 0x5A → wstrb 4'b0100, wdata 0x5A5A5A5A; half to 0x...02 → wstrb 4'b1100.
- Double to 0x1000, data 0x11111111, srcaddr 0x22222222, `wready` low 3 cycles → awlen 1; beat0 0x11111111 wlast 0 held stable; beat1 0x22222222 wlast 1.
- `bvalid` held low, 4 words sent → `wr_wait` stays high after the 4th AW; one B handshake → next packet accepted.
- With macro defined, bresp 2'b10 → `wr_error`=1 and stays set; without the macro it stays 0.
- Deassert `m_axi_aresetn` with `awvalid` high and `awready` low → `awvalid`, `wvalid`, `bready`, `wr_wait` go to 0 immediately.

Source files
------------

// File: rtl/emaxi_wr.sv
// emaxi_wr: emesh write packet to AXI3 write initiator.
// Holds one packet at a time, issues AW and W independently, and tracks
// up to MAX_OUT outstanding B responses.
// Optional feature macro: EMAXI_WR_BRESP_ERR_EN (sticky wr_error on SLVERR/DECERR).
module emaxi_wr #(
  parameter int             IDW     = 12,
  parameter logic [IDW-1:0] AXI_ID  = '0,
  parameter int             MAX_OUT = 4
) (
  input  logic             m_axi_aclk,
  input  logic             m_axi_aresetn,
  input  logic             wr_access,
  input  logic [103:0]     wr_packet,
  output logic             wr_wait,
  output logic [IDW-1:0]   m_axi_awid,
  output logic [31:0]      m_axi_awaddr,
  output logic [7:0]       m_axi_awlen,
  output logic [2:0]       m_axi_awsize,
  output logic [1:0]       m_axi_awburst,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wlast,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [IDW-1:0]   m_axi_bid,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic             wr_error
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  // Registered state
  logic        awvalid_q, awvalid_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic [7:0]  awlen_q,   awlen_d;
  logic [2:0]  awsize_q,  awsize_d;
  logic [1:0]  awburst_q, awburst_d;
  logic        wvalid_q,  wvalid_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [31:0] wdata_hi_q, wdata_hi_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic        wlast_q,   wlast_d;
  logic        beat_q,    beat_d;
  logic [3:0]  out_cnt_q, out_cnt_d;
  logic        wr_error_q, wr_error_d;

  // Packet decode
  logic [31:0] pk_addr;
  logic [31:0] pk_data;
  logic [31:0] pk_data_hi;
  logic [31:0] pk_wdata;
  logic [7:0]  pk_len;
  logic [2:0]  pk_size;
  logic [3:0]  pk_strb;
  logic        pk_last;

  // Handshakes and control
  logic busy;
  logic accept;
  logic load;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic b_err;

  // ctrlmode and bid carry no meaning for the write path
  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_bresp[0], wr_packet[7:3]};

  assign busy   = awvalid_q | wvalid_q;
  assign wr_wait = busy | (out_cnt_q == MAX_OUT_C);
  assign accept = wr_access & ~wr_wait;
  assign load   = accept & wr_packet[0];
  assign aw_hs  = awvalid_q & m_axi_awready;
  assign w_hs   = wvalid_q & m_axi_wready;
  assign b_hs   = m_axi_bvalid & m_axi_bready;

`ifdef EMAXI_WR_BRESP_ERR_EN
  assign b_err = b_hs & m_axi_bresp[1];
`else
  assign b_err = 1'b0;
`endif

  // Translate the incoming packet's datamode into AW/W field values
  always_comb begin
    pk_addr    = wr_packet[39:8];
    pk_data    = wr_packet[71:40];
    pk_data_hi = wr_packet[103:72];
    pk_wdata   = pk_data;
    pk_len     = 8'd0;
    pk_size    = 3'd2;
    pk_strb    = 4'hF;
    pk_last    = 1'b1;
    case (wr_packet[2:1])
      2'b00: begin
        pk_size  = 3'd0;
        pk_strb  = 4'b0001 << pk_addr[1:0];
        pk_wdata = {4{pk_data[7:0]}};
      end
      2'b01: begin
        pk_size    = 3'd1;
        pk_strb    = pk_addr[1] ? 4'b1100 : 4'b0011;
        pk_wdata   = {2{pk_data[15:0]}};
        pk_addr[0] = 1'b0;
      end
      2'b10: begin
        pk_addr[1:0] = 2'b00;
      end
      default: begin
        pk_len       = 8'd1;
        pk_last      = 1'b0;
        pk_addr[2:0] = 3'b000;
      end
    endcase
  end

  // Address channel: load on accept, drop valid after handshake
  always_comb begin
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    if (load) begin
      awvalid_d = 1'b1;
      awaddr_d  = pk_addr;
      awlen_d   = pk_len;
      awsize_d  = pk_size;
      awburst_d = 2'b01;
    end else if (aw_hs) begin
      awvalid_d = 1'b0;
    end
  end

  // Data channel: first beat on load, second beat of a double swaps in the upper word
  always_comb begin
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    wdata_hi_d = wdata_hi_q;
    wstrb_d    = wstrb_q;
    wlast_d    = wlast_q;
    beat_d     = beat_q;
    if (load) begin
      wvalid_d   = 1'b1;
      wdata_d    = pk_wdata;
      wdata_hi_d = pk_data_hi;
      wstrb_d    = pk_strb;
      wlast_d    = pk_last;
      beat_d     = 1'b0;
    end else if (w_hs) begin
      if (wlast_q) begin
        wvalid_d = 1'b0;
      end else begin
        wdata_d = wdata_hi_q;
        wlast_d = 1'b1;
        beat_d  = 1'b1;
      end
    end
  end

  // Outstanding response counter and sticky error
  always_comb begin
    out_cnt_d  = out_cnt_q;
    wr_error_d = wr_error_q | b_err;
    case ({aw_hs, b_hs})
      2'b10:   out_cnt_d = out_cnt_q + 4'd1;
      2'b01:   out_cnt_d = out_cnt_q - 4'd1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // State registers; reset abandons any in-flight transaction
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      awvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      awsize_q   <= '0;
      awburst_q  <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wdata_hi_q <= '0;
      wstrb_q    <= '0;
      wlast_q    <= 1'b0;
      beat_q     <= 1'b0;
      out_cnt_q  <= '0;
      wr_error_q <= 1'b0;
    end else begin
      awvalid_q  <= awvalid_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      awsize_q   <= awsize_d;
      awburst_q  <= awburst_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wdata_hi_q <= wdata_hi_d;
      wstrb_q    <= wstrb_d;
      wlast_q    <= wlast_d;
      beat_q     <= beat_d;
      out_cnt_q  <= out_cnt_d;
      wr_error_q <= wr_error_d;
    end
  end

  // beat index is kept for visibility; wlast already encodes the final beat
  logic unused_beat;
  assign unused_beat = beat_q;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = awsize_q;
  assign m_axi_awburst = awburst_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = (out_cnt_q != 4'd0);
  assign wr_error      = wr_error_q;

endmodule

// File: tb/tb_emaxi_wr.sv
// Scoreboard bench for emaxi_wr: directed packets push expected AW/W
// beats into queues; a negedge monitor compares whenever a valid is shown.
module tb_emaxi_wr;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_access;
  logic [103:0] wr_packet;
  logic         wr_wait;
  logic [11:0]  awid;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast, wvalid, wready;
  logic [11:0]  bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic         wr_error;

  int n_checks = 0;
  int n_pass   = 0;

  logic [44:0] aw_q[$];
  logic [36:0] w_q[$];

`ifdef EMAXI_WR_BRESP_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  emaxi_wr #(.IDW(12), .AXI_ID(12'h000), .MAX_OUT(4)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .wr_access(wr_access), .wr_packet(wr_packet), .wr_wait(wr_wait),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready), .wr_error(wr_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [103:0] mk(input logic wr, input logic [1:0] dm,
                                      input logic [31:0] addr, input logic [31:0] data,
                                      input logic [31:0] src);
    return {src, data, addr, 5'b00000, dm, wr};
  endfunction

  // Present a packet, wait (bounded) until it is taken, push its expected beats.
  task automatic send(input logic [103:0] p, input logic [31:0] ea, input logic [7:0] elen,
                      input logic [2:0] esz, input logic [31:0] d0, input logic [3:0] es,
                      input logic [31:0] d1);
    int n = 0;
    if (p[0]) begin
      aw_q.push_back({ea, elen, esz, 2'b01});
      if (elen == 8'd1) begin
        w_q.push_back({d0, es, 1'b0});
        w_q.push_back({d1, es, 1'b1});
      end else begin
        w_q.push_back({d0, es, 1'b1});
      end
    end
    wr_packet = p;
    wr_access = 1'b1;
    @(negedge clk);
    while (wr_wait && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1 wr_access = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (5) @(posedge clk);
    #1;
  endtask

  // Monitor: compare shown AW/W against queue heads, pop on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (awvalid) begin
        if (aw_q.size() == 0) chk("aw_unexpected", 64'd1, 64'd0);
        else begin
          chk("aw_fields", {19'd0, awaddr, awlen, awsize, awburst}, {19'd0, aw_q[0]});
          chk("awid", {52'd0, awid}, 64'd0);
          if (awready) void'(aw_q.pop_front());
        end
      end
      if (wvalid) begin
        if (w_q.size() == 0) chk("w_unexpected", 64'd1, 64'd0);
        else begin
          chk("w_beat", {27'd0, wdata, wstrb, wlast}, {27'd0, w_q[0]});
          if (wready) void'(w_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_access = 1'b0; wr_packet = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    #12;
    chk("rst_awvalid", {63'd0, awvalid}, 64'd0);
    chk("rst_wvalid",  {63'd0, wvalid}, 64'd0);
    chk("rst_bready",  {63'd0, bready}, 64'd0);
    chk("rst_wr_wait", {63'd0, wr_wait}, 64'd0);
    chk("rst_awburst", {62'd0, awburst}, 64'd0);
    chk("rst_awaddr",  {32'd0, awaddr}, 64'd0);
    chk("rst_wdata_strb_last", {27'd0, wdata, wstrb, wlast}, 64'd0);
    chk("rst_wr_error", {63'd0, wr_error}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bvalid = 1'b1;

    // Word write with timing of wr_wait
    send(mk(1, 2'b10, 32'h8000_0013, 32'hDEAD_BEEF, 32'h0), 32'h8000_0010, 8'd0, 3'd2,
         32'hDEAD_BEEF, 4'hF, 32'h0);
    @(negedge clk);
    chk("word_wait_n1", {63'd0, wr_wait}, 64'd1);
    chk("word_awvalid_n1", {63'd0, awvalid}, 64'd1);
    @(negedge clk);
    chk("word_wait_n2", {63'd0, wr_wait}, 64'd0);
    chk("word_awvalid_n2", {63'd0, awvalid}, 64'd0);
    wait_idle();

    // Byte and half, back to back
    send(mk(1, 2'b00, 32'h3000_0002, 32'h0000_005A, 32'h0), 32'h3000_0002, 8'd0, 3'd0,
         32'h5A5A_5A5A, 4'b0100, 32'h0);
    send(mk(1, 2'b01, 32'h2000_0003, 32'h0000_ABCD, 32'h0), 32'h2000_0002, 8'd0, 3'd1,
         32'hABCD_ABCD, 4'b1100, 32'h0);
    send(mk(1, 2'b01, 32'h2000_0001, 32'h0000_1234, 32'h0), 32'h2000_0000, 8'd0, 3'd1,
         32'h1234_1234, 4'b0011, 32'h0);
    send(mk(1, 2'b00, 32'h3000_0007, 32'h0000_00C3, 32'h0), 32'h3000_0007, 8'd0, 3'd0,
         32'hC3C3_C3C3, 4'b1000, 32'h0);
    wait_idle();

    // Read-flagged packet is accepted and dropped
    send(mk(0, 2'b10, 32'h4000_0000, 32'h1, 32'h0), 32'h0, 8'd0, 3'd0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("drop_awvalid", {63'd0, awvalid}, 64'd0);
    chk("drop_wvalid",  {63'd0, wvalid}, 64'd0);
    chk("drop_wr_wait", {63'd0, wr_wait}, 64'd0);
    wait_idle();

    // Double with wready stalled three cycles
    wready = 1'b0;
    send(mk(1, 2'b11, 32'h0000_1005, 32'h1111_1111, 32'h2222_2222), 32'h0000_1000, 8'd1, 3'd2,
         32'h1111_1111, 4'hF, 32'h2222_2222);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 wready = 1'b1;
    wait_idle();

    // Outstanding limit: no B responses for four words
    bvalid = 1'b0;
    for (int i = 0; i < 4; i++)
      send(mk(1, 2'b10, 32'h5000_0000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'h0),
           32'h5000_0000 + 32'(i * 4), 8'd0, 3'd2, 32'hA000_0000 + 32'(i), 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    chk("max_bready", {63'd0, bready}, 64'd1);
    aw_q.push_back({32'h6000_0000, 8'd0, 3'd2, 2'b01});
    w_q.push_back({32'h0BAD_F00D, 4'hF, 1'b1});
    wr_packet = mk(1, 2'b10, 32'h6000_0000, 32'h0BAD_F00D, 32'h0);
    wr_access = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("max_wr_wait_held", {63'd0, wr_wait}, 64'd1);
      chk("max_no_aw", {63'd0, awvalid}, 64'd0);
    end
    @(posedge clk);
    #1 bvalid = 1'b1;
    @(negedge clk);
    chk("max_wait_before_b", {63'd0, wr_wait}, 64'd1);
    @(negedge clk);
    chk("max_wait_after_b", {63'd0, wr_wait}, 64'd0);
    @(posedge clk);
    #1 wr_access = 1'b0;
    @(negedge clk);
    chk("max_fifth_awvalid", {63'd0, awvalid}, 64'd1);
    wait_idle();

    // Error response
    bresp = 2'b10;
    send(mk(1, 2'b10, 32'h7000_0000, 32'h1, 32'h0), 32'h7000_0000, 8'd0, 3'd2, 32'h1, 4'hF, 32'h0);
    wait_idle();
    chk("err_set", {63'd0, wr_error}, {63'd0, ERR_EXP});
    bresp = 2'b00;
    send(mk(1, 2'b10, 32'h7000_0004, 32'h2, 32'h0), 32'h7000_0004, 8'd0, 3'd2, 32'h2, 4'hF, 32'h0);
    wait_idle();
    chk("err_sticky", {63'd0, wr_error}, {63'd0, ERR_EXP});

    // Reset mid-transaction
    bvalid = 1'b0;
    send(mk(1, 2'b10, 32'h9000_0000, 32'h3, 32'h0), 32'h9000_0000, 8'd0, 3'd2, 32'h3, 4'hF, 32'h0);
    wait_idle();
    awready = 1'b0;
    send(mk(1, 2'b10, 32'h9000_0004, 32'h4, 32'h0), 32'h9000_0004, 8'd0, 3'd2, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    chk("pre_rst_awvalid", {63'd0, awvalid}, 64'd1);
    chk("pre_rst_bready",  {63'd0, bready}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_awvalid", {63'd0, awvalid}, 64'd0);
    chk("mid_rst_wvalid",  {63'd0, wvalid}, 64'd0);
    chk("mid_rst_bready",  {63'd0, bready}, 64'd0);
    chk("mid_rst_wr_wait", {63'd0, wr_wait}, 64'd0);
    chk("mid_rst_wr_error", {63'd0, wr_error}, 64'd0);
    aw_q.delete();
    w_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    awready = 1'b1;
    bvalid = 1'b1;
    send(mk(1, 2'b11, 32'hA000_0008, 32'hCAFE_0001, 32'hCAFE_0002), 32'hA000_0008, 8'd1, 3'd2,
         32'hCAFE_0001, 4'hF, 32'hCAFE_0002);
    wait_idle();

    chk("aw_queue_drained", 64'(aw_q.size()), 64'd0);
    chk("w_queue_drained",  64'(w_q.size()), 64'd0);
    chk("end_bready", {63'd0, bready}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
